// File: rtl/if_stage_if.sv
// Fetch-stage bundle: control from the hazard/branch logic, the IMEM port and the IF/ID view.
// The master modport is the fetch stage; the slave modport is its environment.
interface if_stage_if #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH   = 16
);
    logic                   if_stall;
    logic                   if_flush;
    logic                   if_redirect;
    logic [PC_WIDTH-1:0]    if_redirect_pc;
    logic [INSTR_WIDTH-1:0] if_imem_instr;
    logic [PC_WIDTH-1:0]    if_imem_pc;
    logic [PC_WIDTH-1:0]    id_pc;
    logic [PC_WIDTH-1:0]    id_pc_plus4;
    logic [INSTR_WIDTH-1:0] id_instruction;
    logic                   id_valid;
    logic                   if_halted;
    logic [CNT_WIDTH-1:0]   fetch_count;

    modport master (
        input  if_stall, if_flush, if_redirect, if_redirect_pc, if_imem_instr,
        output if_imem_pc, id_pc, id_pc_plus4, id_instruction, id_valid, if_halted, fetch_count
    );

    modport slave (
        output if_stall, if_flush, if_redirect, if_redirect_pc, if_imem_instr,
        input  if_imem_pc, id_pc, id_pc_plus4, id_instruction, id_valid, if_halted, fetch_count
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, feeds IMEM and fills the IF/ID register.
// Handles stall, flush, redirect, a HALT state and a retired-fetch counter.
module if_stage #(
    parameter int unsigned             PC_WIDTH    = 8,
    parameter int unsigned             INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0]  HALT_WORD   = '1,
    parameter int unsigned             CNT_WIDTH   = 16
) (
    input  logic        clk,
    input  logic        rst,
    if_stage_if.master  bus
);
    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    state_t                 r_state, w_state_nxt;
    logic [PC_WIDTH-1:0]    r_pc, w_pc_nxt;
    logic [PC_WIDTH-1:0]    r_id_pc, w_id_pc_nxt;
    logic [PC_WIDTH-1:0]    r_id_pc_plus4, w_id_pc_plus4_nxt;
    logic [INSTR_WIDTH-1:0] r_id_instr, w_id_instr_nxt;
    logic                   r_id_valid, w_id_valid_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;

    logic [PC_WIDTH-1:0]    w_pc_inc;
    logic [PC_WIDTH-1:0]    w_target;
    logic                   w_kill;
    logic                   w_halted;

    assign w_pc_inc = r_pc + PC_WIDTH'(4);
    assign w_target = bus.if_redirect_pc & ~PC_WIDTH'(3);
    assign w_kill   = bus.if_flush | bus.if_redirect;
    assign w_halted = (r_state == S_HALT);

    // Next PC, IF/ID contents and state; stall is ignored while halted.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_id_pc_nxt       = r_id_pc;
        w_id_pc_plus4_nxt = r_id_pc_plus4;
        w_id_instr_nxt    = r_id_instr;
        w_id_valid_nxt    = r_id_valid;
        w_cnt_nxt         = r_cnt;

        if (bus.if_redirect) begin
            w_pc_nxt = w_target;
        end else if (!w_halted && !bus.if_stall) begin
            w_pc_nxt = w_pc_inc;
        end

        if (w_kill || w_halted) begin
            w_id_valid_nxt = 1'b0;
            w_id_instr_nxt = '0;
        end else if (!bus.if_stall) begin
            w_id_pc_nxt       = r_pc;
            w_id_pc_plus4_nxt = w_pc_inc;
            w_id_instr_nxt    = bus.if_imem_instr;
            w_id_valid_nxt    = 1'b1;
            w_cnt_nxt         = r_cnt + CNT_WIDTH'(1);
        end

        case (r_state)
            S_RUN: begin
                if (!w_kill && !bus.if_stall && bus.if_imem_instr == HALT_WORD)
                    w_state_nxt = S_HALT;
            end
            S_HALT: begin
                if (bus.if_redirect)
                    w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_pc          <= RESET_PC;
            r_id_pc       <= '0;
            r_id_pc_plus4 <= '0;
            r_id_instr    <= '0;
            r_id_valid    <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_id_pc       <= w_id_pc_nxt;
            r_id_pc_plus4 <= w_id_pc_plus4_nxt;
            r_id_instr    <= w_id_instr_nxt;
            r_id_valid    <= w_id_valid_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign bus.if_imem_pc     = r_pc;
    assign bus.id_pc          = r_id_pc;
    assign bus.id_pc_plus4    = r_id_pc_plus4;
    assign bus.id_instruction = r_id_instr;
    assign bus.id_valid       = r_id_valid;
    assign bus.if_halted      = w_halted;
    assign bus.fetch_count    = r_cnt;
endmodule
